// File: rtl/can_frame_player.sv
// can_frame_player: FIFO-buffered CAN bit-stream source for the receive line.
// Define CAN_PLAYER_STUFF_EN to insert stuff bits after five identical bits.
module can_frame_player #(
  parameter int MAX_LEN = 151,
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 8,
  parameter int GAP     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               samplePoint,
  input  logic               wrEn,
  input  logic [MAX_LEN-1:0] wrData,
  input  logic [LEN_W-1:0]   wrLen,
  output logic               full,
  output logic               wrErr,
  output logic               canRX,
  output logic               isStuff,
  output logic               busy,
  output logic               frameStart,
  output logic               frameDone,
  output logic [LEN_W-1:0]   bitCount
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(GAP + 1);
  localparam int EW = LEN_W + MAX_LEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  logic [EW-1:0]      mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic               empty;
  logic               pop;
  logic               push;
  logic               len_ok;
  logic [LEN_W-1:0]   rd_len;
  logic [MAX_LEN-1:0] rd_data;
  logic [LEN_W-1:0]   shamt;
  logic [MAX_LEN-1:0] aligned;

  state_t             state;
  state_t             state_n;
  logic [MAX_LEN-1:0] shreg;
  logic [MAX_LEN-1:0] shreg_n;
  logic [LEN_W-1:0]   rem;
  logic [LEN_W-1:0]   rem_n;
  logic [LEN_W-1:0]   bcnt_n;
  logic [GW-1:0]      gcnt;
  logic [GW-1:0]      gcnt_n;
  logic               rx_n;
  logic               start_n;
  logic               done_n;
  logic               stuff_due;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign busy  = (state != S_IDLE) || !empty;

  assign {rd_len, rd_data} = mem[rd_ptr[AW-1:0]];
  assign len_ok = (wrLen != '0) && (wrLen <= LEN_W'(MAX_LEN));
  assign push   = wrEn && len_ok && (!full || pop);

  // Left-align the frame so the first bit always sits at the MSB.
  assign shamt   = LEN_W'(MAX_LEN) - rd_len;
  assign aligned = rd_data << shamt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {wrLen, wrData};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      wrErr  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      wrErr <= wrEn && !push;
    end
  end

`ifdef CAN_PLAYER_STUFF_EN
  logic [2:0] run;
  logic [2:0] run_n;
  logic       stuff_n;

  assign stuff_due = run == 3'd5;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run     <= '0;
      isStuff <= 1'b0;
    end else begin
      run     <= run_n;
      isStuff <= stuff_n;
    end
  end
`else
  assign stuff_due = 1'b0;
  assign isStuff   = 1'b0;
`endif

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    rem_n   = rem;
    bcnt_n  = bitCount;
    gcnt_n  = gcnt;
    rx_n    = canRX;
    start_n = 1'b0;
    done_n  = 1'b0;
    pop     = 1'b0;
`ifdef CAN_PLAYER_STUFF_EN
    run_n   = run;
    stuff_n = isStuff;
`endif
    if (samplePoint) begin
      unique case (state)
        S_IDLE: begin
          rx_n = 1'b1;
`ifdef CAN_PLAYER_STUFF_EN
          stuff_n = 1'b0;
`endif
          if (!empty) begin
            pop     = 1'b1;
            rx_n    = aligned[MAX_LEN-1];
            shreg_n = aligned << 1;
            rem_n   = rd_len - LEN_W'(1);
            bcnt_n  = LEN_W'(1);
            start_n = 1'b1;
            state_n = S_SEND;
`ifdef CAN_PLAYER_STUFF_EN
            run_n   = 3'd1;
`endif
          end
        end
        S_SEND: begin
          if (stuff_due) begin
            rx_n = ~canRX;
`ifdef CAN_PLAYER_STUFF_EN
            stuff_n = 1'b1;
            run_n   = 3'd1;
`endif
          end else if (rem == '0) begin
            rx_n    = 1'b1;
            done_n  = 1'b1;
            gcnt_n  = GW'(1);
            state_n = (GAP == 1) ? S_IDLE : S_GAP;
`ifdef CAN_PLAYER_STUFF_EN
            stuff_n = 1'b0;
`endif
          end else begin
            rx_n    = shreg[MAX_LEN-1];
            shreg_n = shreg << 1;
            rem_n   = rem - LEN_W'(1);
            bcnt_n  = bitCount + LEN_W'(1);
`ifdef CAN_PLAYER_STUFF_EN
            stuff_n = 1'b0;
            run_n   = (shreg[MAX_LEN-1] == canRX) ? run + 3'd1 : 3'd1;
`endif
          end
        end
        S_GAP: begin
          rx_n   = 1'b1;
          gcnt_n = gcnt + GW'(1);
          if (gcnt_n == GW'(GAP)) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      rem        <= '0;
      bitCount   <= '0;
      gcnt       <= '0;
      canRX      <= 1'b1;
      frameStart <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      rem        <= rem_n;
      bitCount   <= bcnt_n;
      gcnt       <= gcnt_n;
      canRX      <= rx_n;
      frameStart <= start_n;
      frameDone  <= done_n;
    end
  end

endmodule

// File: tb/tb_can_frame_player.sv
// tb_can_frame_player: directed and random checks of can_frame_player
// against a frame-level reference model of the serial line.
`timescale 1ns/1ps
module tb_can_frame_player;
  localparam int MAX_LEN = 151;
  localparam int DEPTH   = 4;
  localparam int LEN_W   = 8;
  localparam int GAP     = 3;
`ifdef CAN_PLAYER_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               samplePoint = 1'b0;
  logic               wrEn = 1'b0;
  logic [MAX_LEN-1:0] wrData = '0;
  logic [LEN_W-1:0]   wrLen = '0;
  logic               full;
  logic               wrErr;
  logic               canRX;
  logic               isStuff;
  logic               busy;
  logic               frameStart;
  logic               frameDone;
  logic [LEN_W-1:0]   bitCount;

  always #5 clk = ~clk;

  can_frame_player #(
    .MAX_LEN(MAX_LEN),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W),
    .GAP    (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .samplePoint(samplePoint),
    .wrEn       (wrEn),
    .wrData     (wrData),
    .wrLen      (wrLen),
    .full       (full),
    .wrErr      (wrErr),
    .canRX      (canRX),
    .isStuff    (isStuff),
    .busy       (busy),
    .frameStart (frameStart),
    .frameDone  (frameDone),
    .bitCount   (bitCount)
  );

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: each accepted frame expands into a list of
  // per-tick line events (data, stuff, done, gap bits).
  typedef struct {
    logic rx;
    logic stf;
    logic fs;
    logic fd;
    int   bc;
  } ev_t;
  typedef struct {
    int                 len;
    logic [MAX_LEN-1:0] data;
  } fr_t;

  ev_t ev_q[$];
  fr_t fq[$];
  logic e_rx = 1'b1, e_stf = 1'b0, e_fs = 1'b0, e_fd = 1'b0, e_err = 1'b0;
  int   e_bc = 0;

  function automatic void add_ev(logic rx, logic stf, logic fs, logic fd, int bc);
    ev_t e;
    e.rx = rx; e.stf = stf; e.fs = fs; e.fd = fd; e.bc = bc;
    ev_q.push_back(e);
  endfunction

  function automatic void expand(fr_t f);
    int   run = 0;
    logic last = 1'b1;
    for (int i = f.len - 1; i >= 0; i--) begin
      if (STUFF && run == 5) begin
        add_ev(~last, 1'b1, 1'b0, 1'b0, f.len - 1 - i);
        last = ~last;
        run  = 1;
      end
      add_ev(f.data[i], 1'b0, i == f.len - 1, 1'b0, f.len - i);
      run  = (i != f.len - 1 && f.data[i] == last) ? run + 1 : 1;
      last = f.data[i];
    end
    if (STUFF && run == 5) add_ev(~last, 1'b1, 1'b0, 1'b0, f.len);
    add_ev(1'b1, 1'b0, 1'b0, 1'b1, f.len);
    for (int g = 1; g < GAP; g++) add_ev(1'b1, 1'b0, 1'b0, 1'b0, f.len);
  endfunction

  initial forever begin
    bit  m_pop;
    bit  m_ok;
    ev_t m_e;
    fr_t m_f;
    @(posedge clk or posedge rst);
    if (rst) begin
      ev_q.delete();
      fq.delete();
      e_rx = 1'b1; e_stf = 1'b0; e_fs = 1'b0; e_fd = 1'b0;
      e_err = 1'b0; e_bc = 0;
    end else begin
      m_pop = 1'b0;
      e_fs  = 1'b0;
      e_fd  = 1'b0;
      if (samplePoint) begin
        if (ev_q.size() == 0 && fq.size() > 0) begin
          m_pop = 1'b1;
          expand(fq.pop_front());
        end
        if (ev_q.size() > 0) begin
          m_e   = ev_q.pop_front();
          e_rx  = m_e.rx;
          e_stf = m_e.stf;
          e_fs  = m_e.fs;
          e_fd  = m_e.fd;
          e_bc  = m_e.bc;
        end else begin
          e_rx  = 1'b1;
          e_stf = 1'b0;
        end
      end
      m_ok = wrEn && int'(wrLen) >= 1 && int'(wrLen) <= MAX_LEN &&
             (fq.size() < DEPTH || m_pop);
      e_err = wrEn && !m_ok;
      if (m_ok) begin
        m_f.len  = int'(wrLen);
        m_f.data = wrData;
        fq.push_back(m_f);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en && !rst) begin
      chk("canRX", canRX, e_rx);
      chk("isStuff", isStuff, e_stf);
      chk("frameStart", frameStart, e_fs);
      chk("frameDone", frameDone, e_fd);
      chk("bitCount", bitCount, e_bc);
      chk("wrErr", wrErr, e_err);
      chk("full", full, fq.size() == DEPTH);
      chk("busy", busy, ev_q.size() != 0 || fq.size() != 0);
    end
  end

  logic lrx[$], lstf[$], lfs[$], lfd[$];
  int   lbc[$];

  function automatic void clear_log();
    lrx.delete(); lstf.delete(); lfs.delete(); lfd.delete(); lbc.delete();
  endfunction

  task automatic push(int len, logic [MAX_LEN-1:0] d);
    @(negedge clk);
    wrEn   = 1'b1;
    wrLen  = LEN_W'(len);
    wrData = d;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    samplePoint = 1'b1;
    @(negedge clk);
    samplePoint = 1'b0;
    lrx.push_back(canRX);
    lstf.push_back(isStuff);
    lfs.push_back(frameStart);
    lfd.push_back(frameDone);
    lbc.push_back(int'(bitCount));
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && (ev_q.size() != 0 || fq.size() != 0); n++)
      tick();
    chk("drain_idle", busy, 1'b0);
  endtask

  function automatic logic [MAX_LEN-1:0] rnd_data();
    logic [MAX_LEN-1:0] d;
    for (int i = 0; i < MAX_LEN; i++) d[i] = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      1: d = '0;
      2: d = '1;
      3: for (int i = 1; i < MAX_LEN; i++)
           d[i] = ($urandom_range(0, 7) == 0) ? ~d[i-1] : d[i-1];
      default: ;
    endcase
    return d;
  endfunction

  function automatic int rnd_len();
    int r = $urandom_range(0, 19);
    if (r == 0) return 0;
    if (r == 1) return $urandom_range(MAX_LEN + 1, 255);
    if (r < 8) return $urandom_range(1, 12);
    return $urandom_range(1, MAX_LEN);
  endfunction

  task automatic check_f11(string tag);
    logic [10:0] pat = 11'b11001001001;
    for (int i = 0; i < 11; i++)
      chk($sformatf("%s_bit%0d", tag, i + 1), lrx[i], pat[10-i]);
    chk({tag, "_start"}, lfs[0], 1'b1);
    chk({tag, "_done"}, lfd[11], 1'b1);
    chk({tag, "_bc"}, lbc[11], 11);
    chk({tag, "_gap"}, {lrx[11], lrx[12], lrx[13]}, 3'b111);
    chk({tag, "_bc_idle"}, lbc[14], 11);
  endtask

  initial begin
    logic [7:0] spat;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_canRX", canRX, 1'b1);
    chk("rst_isStuff", isStuff, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_bitCount", bitCount, 0);

    clear_log();
    push(11, MAX_LEN'(11'b11001001001));
    repeat (15) tick();
    check_f11("f11");

    clear_log();
    push(4, MAX_LEN'(4'b1010));
    push(5, MAX_LEN'(5'b10110));
    repeat (16) tick();
    chk("gap_f1_done", lfd[4], 1'b1);
    chk("gap_recessive", {lrx[4], lrx[5], lrx[6]}, 3'b111);
    chk("gap_no_early", {lfs[4], lfs[5], lfs[6]}, 3'b000);
    chk("gap_f2_start", lfs[7], 1'b1);

    for (int k = 0; k < 4; k++) push(3, MAX_LEN'(3'b101));
    chk("full_after4", full, 1'b1);
    chk("err_4th", wrErr, 1'b0);
    push(3, MAX_LEN'(3'b011));
    chk("err_5th", wrErr, 1'b1);
    @(negedge clk);
    samplePoint = 1'b1;
    wrEn = 1'b1;
    wrLen = LEN_W'(3);
    wrData = MAX_LEN'(3'b110);
    @(negedge clk);
    samplePoint = 1'b0;
    wrEn = 1'b0;
    chk("popush_err", wrErr, 1'b0);
    chk("popush_full", full, 1'b1);
    drain();

    push(0, '1);
    chk("len0_err", wrErr, 1'b1);
    chk("len0_busy", busy, 1'b0);
    push(MAX_LEN + 1, '1);
    chk("len152_err", wrErr, 1'b1);
    chk("len152_busy", busy, 1'b0);

    clear_log();
    push(7, MAX_LEN'(7'b0000011));
    repeat (12) tick();
`ifdef CAN_PLAYER_STUFF_EN
    spat = 8'b00000111;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stf_bit%0d", i + 1), lrx[i], spat[7-i]);
      chk($sformatf("stf_flag%0d", i + 1), lstf[i], i == 5);
    end
    chk("stf_done", lfd[8], 1'b1);
    chk("stf_bc", lbc[8], 7);
`else
    spat = 8'b00000011;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("stf_bit%0d", i + 1), lrx[i], spat[6-i]);
      chk($sformatf("stf_flag%0d", i + 1), lstf[i], 1'b0);
    end
    chk("stf_done", lfd[7], 1'b1);
    chk("stf_bc", lbc[7], 7);
`endif

    clear_log();
    push(11, MAX_LEN'(11'b11001001001));
    repeat (5) tick();
    chk("mid_bc5", lbc[4], 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_canRX", canRX, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_full", full, 1'b0);
    chk("mid_rst_bc", bitCount, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    clear_log();
    push(11, MAX_LEN'(11'b11001001001));
    repeat (15) tick();
    check_f11("after_rst");

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      samplePoint = !samplePoint && ($urandom_range(0, 1) == 1);
      wrEn   = $urandom_range(0, 9) == 0;
      wrLen  = LEN_W'(rnd_len());
      wrData = rnd_data();
    end
    @(negedge clk);
    samplePoint = 1'b0;
    wrEn = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/can_frame_player.md
# can_frame_player

Synthesizable, parametrised CAN bit-stream source that replaces hand-shifted bench stimulus on the receive line. Queues up to DEPTH frames of up to MAX_LEN bits, serialises each MSB-first onto canRX, one bit per samplePoint tick, and inserts a recessive interframe gap. Optional bit-stuff insertion drives isStuff alongside canRX, so frameMakerTop and later receive-path blocks can be exercised in simulation and on FPGA from one source.

## Interface
- MAX_LEN, 151: maximum frame length in bits (stored width)
- DEPTH, 4: frame FIFO depth (power of two, ≥2)
- LEN_W, 8: width of length field; must satisfy 2^LEN_W > MAX_LEN
- GAP, 3: recessive bit times inserted after every frame (≥1)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- samplePoint  in  1  one-clk-wide bit-time tick; all serial activity advances only on it
- wrEn  in  1  push request
- wrData  in  MAX_LEN  frame bits, right-aligned; first transmitted bit is wrData[wrLen-1]
- wrLen  in  LEN_W  number of bits, valid range 1..MAX_LEN
- full  out  1  FIFO holds DEPTH entries
- wrErr  out  1  one-clk pulse: push rejected (full, or wrLen 0 / > MAX_LEN)
- canRX  out  1  serial line, 1 = recessive
- isStuff  out  1  current canRX bit is an inserted stuff bit
- busy  out  1  state ≠ IDLE or FIFO non-empty
- frameStart  out  1  one-clk pulse on the tick the first bit is driven
- frameDone  out  1  one-clk pulse on the tick the last bit period ends
- bitCount  out  LEN_W  data bits of current frame already driven (stuff bits excluded)

## Operation
- Reset values: canRX=1, isStuff=0, full=0, wrErr=0, busy=0, frameStart=0, frameDone=0, bitCount=0, FIFO empty, state IDLE.
- FIFO: circular, DEPTH entries of {wrLen, wrData}; ptrs LOG2(DEPTH)+1 bits for full/empty. Push accepted when wrEn and valid wrLen and (not full, or pop in same clk). Rejected push: no state change, wrErr pulse.
- States:
  - IDLE: canRX=1. On samplePoint with FIFO non-empty: pop into shift reg and remaining-count, drive first bit, frameStart, bitCount=1, → SEND.
  - SEND: each samplePoint drives next data bit, bitCount+1. On the samplePoint after the last data bit (and pending stuff bit, if any): canRX=1, frameDone, gap counter=1, → GAP (GAP=1 → IDLE directly).
  - GAP: canRX=1; each samplePoint increments gap counter; when it reaches GAP → IDLE. IDLE may start next frame on the very next samplePoint, giving exactly GAP recessive bit times between frames.
- samplePoint low: all outputs hold (pulses last one clk only).
- bitCount holds its final value through GAP; cleared at next frameStart.

## Timing
- Outputs registered; canRX changes one clk after the samplePoint clk edge that caused it.
- Minimum push-to-line latency: push at clk n, samplePoint at n+1 → canRX valid at n+2.
- Frame of L bits, no stuff: L bit times on line, then GAP recessive bit times.
- Reset mid-frame: immediate return to reset values; FIFO flushed.

## Configuration
- CAN_PLAYER_STUFF_EN defined: run counter of identical consecutive canRX bits, cleared at frameStart. After 5 identical bits, next samplePoint drives the complement with isStuff=1; shift reg and bitCount hold. Stuff bit begins a new run of length 1. Stuff insertion also applies after the final data bit before frameDone.
- Undefined: no insertion; isStuff tied 0; run counter absent.

## Test plan
- Single frame wrLen=11, wrData=11'b11001001001 → canRX sequence 1,1,0,0,1,0,0,1,0,0,1 on 11 ticks, frameStart on tick 1, frameDone on tick 12, then 3 recessive ticks, bitCount=11.
- Two frames pushed back-to-back (lens 4 and 5) → exactly GAP=3 recessive bit times between last bit of frame 1 and first bit of frame 2.
- Push 5 frames with DEPTH=4, no samplePoint → full=1 after 4th, 5th gives wrErr pulse; pop then simultaneous push accepted without wrErr.
- wrLen=0 and wrLen=152 → wrErr each, FIFO level unchanged.
- CAN_PLAYER_STUFF_EN, wrLen=7, wrData=7'b0000011 → 0,0,0,0,0,1(isStuff=1),1,1; frameDone on tick 9, bitCount=7; with macro undefined → 7 bits, isStuff always 0.
- Assert rst during bit 5 of an 11-bit frame → canRX=1, busy=0, FIFO empty within same clk; fresh push transmits normally.
